// File: rtl/pipeline_block_stats_pkg.sv
// Shared constants for the block statistics pipeline stage: FSM state
// encodings, accumulator widths and a small saturation-free add helper.
package pipeline_block_stats_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // Sample and accumulator widths; 11 bits hold 8 x 255 = 2040
  localparam int unsigned DATA_W = 8;
  localparam int unsigned SUM_W  = 11;
  localparam int unsigned IDX_W  = 4;

  // Extend an 8-bit sample and add it to the running sum
  function automatic logic [SUM_W-1:0] sum_add(input logic [SUM_W-1:0] acc,
                                               input logic [DATA_W-1:0] smp);
    sum_add = acc + {{(SUM_W-DATA_W){1'b0}}, smp};
  endfunction

endpackage

// File: rtl/pipeline_block_stats_block_minmax.sv
// Registered running max/min tracker. load seeds both trackers with the
// sample, upd folds a sample in (ties keep the stored value), clr zeroes.
module block_minmax
  import pipeline_block_stats_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              upd_i,
  input  logic [DATA_W-1:0] d_i,
  output logic [DATA_W-1:0] max_o,
  output logic [DATA_W-1:0] min_o
);

  logic [DATA_W-1:0] max_d, max_q;
  logic [DATA_W-1:0] min_d, min_q;

  // Next-state selection: clear beats load beats update
  always_comb begin
    max_d = max_q;
    min_d = min_q;
    if (clr_i) begin
      max_d = {DATA_W{1'b0}};
      min_d = {DATA_W{1'b0}};
    end else if (load_i) begin
      max_d = d_i;
      min_d = d_i;
    end else if (upd_i) begin
      if (d_i > max_q) begin
        max_d = d_i;
      end else begin
        max_d = max_q;
      end
      if (d_i < min_q) begin
        min_d = d_i;
      end else begin
        min_d = min_q;
      end
    end else begin
      max_d = max_q;
      min_d = min_q;
    end
  end

  // Tracker registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      max_q <= {DATA_W{1'b0}};
      min_q <= {DATA_W{1'b0}};
    end else begin
      max_q <= max_d;
      min_q <= min_d;
    end
  end

  assign max_o = max_q;
  assign min_o = min_q;

endmodule

// File: rtl/pipeline_block_stats.sv
// Collects BLOCK_LEN samples from an upstream stage and presents their sum,
// max and min as one result with a valid/ready handshake. Upstream is
// stalled while a result waits for the consumer.
module pipeline_block_stats
  import pipeline_block_stats_pkg::*;
#(
  parameter int unsigned BLOCK_LEN = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic [DATA_W-1:0] y_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [SUM_W-1:0]  sum_out,
  output logic [DATA_W-1:0] max_out,
  output logic [DATA_W-1:0] min_out,
  output logic [7:0]        blk_cnt,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_LEN);

  logic [1:0]       state_d, state_q;
  logic [IDX_W-1:0] idx_d, idx_q;
  logic [SUM_W-1:0] sum_d, sum_q;
  logic [7:0]       cnt_d, cnt_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             accept_s;
  logic             mm_clr_s;
  logic             mm_load_s;
  logic             mm_upd_s;

  // in_ready_q is only ever high outside HOLD, so this is the handshake
  assign accept_s = in_valid & in_ready_q;

  // FSM and accumulator next-state logic
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    mm_clr_s  = 1'b0;
    mm_load_s = 1'b0;
    mm_upd_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          idx_d    = {IDX_W{1'b0}};
          sum_d    = {SUM_W{1'b0}};
          mm_clr_s = 1'b1;
        end else if (accept_s) begin
          state_d   = ST_ACCUM;
          idx_d     = {{(IDX_W-1){1'b0}}, 1'b1};
          sum_d     = sum_add({SUM_W{1'b0}}, y_in);
          mm_load_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (clear) begin
          state_d  = ST_IDLE;
          idx_d    = {IDX_W{1'b0}};
          sum_d    = {SUM_W{1'b0}};
          mm_clr_s = 1'b1;
        end else if (accept_s) begin
          idx_d    = idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
          sum_d    = sum_add(sum_q, y_in);
          mm_upd_s = 1'b1;
          if (idx_d == LAST_IDX) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_ACCUM;
          end
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        // clear is deliberately ignored here: a finished result is never lost
        if (out_ready) begin
          state_d = ST_IDLE;
          idx_d   = {IDX_W{1'b0}};
          cnt_d   = cnt_q + 8'd1;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        idx_d    = {IDX_W{1'b0}};
        sum_d    = {SUM_W{1'b0}};
        mm_clr_s = 1'b1;
      end
    endcase
  end

  // State, accumulator and registered handshake flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= {IDX_W{1'b0}};
      sum_q       <= {SUM_W{1'b0}};
      cnt_q       <= 8'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= (state_d != ST_HOLD);
      out_valid_q <= (state_d == ST_HOLD);
    end
  end

  block_minmax u_minmax (
    .clk_i  (clock),
    .rst_ni (reset),
    .clr_i  (mm_clr_s),
    .load_i (mm_load_s),
    .upd_i  (mm_upd_s),
    .d_i    (y_in),
    .max_o  (max_out),
    .min_o  (min_out)
  );

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum_out   = sum_q;
  assign blk_cnt   = cnt_q;

endmodule

// File: tb/tb_pipeline_block_stats.sv
// Directed bench for pipeline_block_stats (BLOCK_LEN = 4): a vector table
// for the streaming cases plus hand-written reset and wrap sequences.
module tb_pipeline_block_stats;

  logic        clock;
  logic        reset;
  logic        clear;
  logic [7:0]  y_in;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] sum_out;
  logic [7:0]  max_out;
  logic [7:0]  min_out;
  logic [7:0]  blk_cnt;
  logic        out_valid;
  logic        out_ready;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic        clr;
    logic        vld;
    logic [7:0]  y;
    logic        ordy;
    logic        ov;
    logic        ir;
    logic        cd;    // compare the data outputs on this row
    logic [10:0] sum;
    logic [7:0]  mx;
    logic [7:0]  mn;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vt[$];

  pipeline_block_stats #(.BLOCK_LEN(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .y_in      (y_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_out   (sum_out),
    .max_out   (max_out),
    .min_out   (min_out),
    .blk_cnt   (blk_cnt),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic ov, input logic ir,
                       input logic cd, input logic [10:0] s, input logic [7:0] mx,
                       input logic [7:0] mn, input logic [7:0] c);
    logic bad;
    n_vec++;
    bad = (out_valid !== ov) || (in_ready !== ir) || (blk_cnt !== c);
    if (cd) bad = bad || (sum_out !== s) || (max_out !== mx) || (min_out !== mn);
    if (bad) begin
      n_bad++;
      $display("FAIL %s: got ov=%0b ir=%0b sum=%0d max=%0d min=%0d cnt=%0d, want ov=%0b ir=%0b sum=%0d max=%0d min=%0d cnt=%0d (data checked=%0b)",
               name, out_valid, in_ready, sum_out, max_out, min_out, blk_cnt,
               ov, ir, s, mx, mn, c, cd);
    end
  endtask

  task automatic add(input logic clr, input logic vld, input logic [7:0] y,
                     input logic ordy, input logic ov, input logic ir, input logic cd,
                     input logic [10:0] s, input logic [7:0] mx, input logic [7:0] mn,
                     input logic [7:0] c);
    vec_t v;
    v.clr = clr; v.vld = vld; v.y = y; v.ordy = ordy;
    v.ov = ov; v.ir = ir; v.cd = cd; v.sum = s; v.mx = mx; v.mn = mn; v.cnt = c;
    vt.push_back(v);
  endtask

  task automatic drive(input logic clr, input logic vld, input logic [7:0] y,
                       input logic ordy);
    clear = clr; in_valid = vld; y_in = y; out_ready = ordy;
  endtask

  initial begin
    drive(1'b0, 1'b0, 8'd0, 1'b0);
    reset = 1'b0;

    //      clr   vld   y       ordy  ov    ir    cd    sum      max     min     cnt
    // First block 6,10,14,18 then a 5-cycle stall with junk and clear ignored
    add(1'b0, 1'b1, 8'd6,   1'b0, 1'b0, 1'b1, 1'b0, 11'd0,   8'd0,   8'd0,   8'd0);
    add(1'b0, 1'b1, 8'd10,  1'b0, 1'b0, 1'b1, 1'b0, 11'd0,   8'd0,   8'd0,   8'd0);
    add(1'b0, 1'b1, 8'd14,  1'b0, 1'b0, 1'b1, 1'b0, 11'd0,   8'd0,   8'd0,   8'd0);
    add(1'b0, 1'b1, 8'd18,  1'b0, 1'b1, 1'b0, 1'b1, 11'd48,  8'd18,  8'd6,   8'd0);
    add(1'b0, 1'b1, 8'd99,  1'b0, 1'b1, 1'b0, 1'b1, 11'd48,  8'd18,  8'd6,   8'd0);
    add(1'b1, 1'b1, 8'd1,   1'b0, 1'b1, 1'b0, 1'b1, 11'd48,  8'd18,  8'd6,   8'd0);
    add(1'b0, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 1'b1, 11'd48,  8'd18,  8'd6,   8'd0);
    add(1'b1, 1'b0, 8'd0,   1'b0, 1'b1, 1'b0, 1'b1, 11'd48,  8'd18,  8'd6,   8'd0);
    add(1'b0, 1'b1, 8'd200, 1'b0, 1'b1, 1'b0, 1'b1, 11'd48,  8'd18,  8'd6,   8'd0);
    add(1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 1'b1, 1'b0, 11'd0,   8'd0,   8'd0,   8'd1);
    // 255 x4 then 0 x4 with out_ready held high; the y=0 on the release
    // cycle is not accepted because in_ready is low in HOLD
    add(1'b0, 1'b1, 8'd255, 1'b1, 1'b0, 1'b1, 1'b0, 11'd0,   8'd0,   8'd0,   8'd1);
    add(1'b0, 1'b1, 8'd255, 1'b1, 1'b0, 1'b1, 1'b0, 11'd0,   8'd0,   8'd0,   8'd1);
    add(1'b0, 1'b1, 8'd255, 1'b1, 1'b0, 1'b1, 1'b0, 11'd0,   8'd0,   8'd0,   8'd1);
    add(1'b0, 1'b1, 8'd255, 1'b1, 1'b1, 1'b0, 1'b1, 11'd1020, 8'd255, 8'd255, 8'd1);
    add(1'b0, 1'b1, 8'd0,   1'b1, 1'b0, 1'b1, 1'b0, 11'd0,   8'd0,   8'd0,   8'd2);
    add(1'b0, 1'b1, 8'd0,   1'b1, 1'b0, 1'b1, 1'b0, 11'd0,   8'd0,   8'd0,   8'd2);
    add(1'b0, 1'b1, 8'd0,   1'b1, 1'b0, 1'b1, 1'b0, 11'd0,   8'd0,   8'd0,   8'd2);
    add(1'b0, 1'b1, 8'd0,   1'b1, 1'b0, 1'b1, 1'b0, 11'd0,   8'd0,   8'd0,   8'd2);
    add(1'b0, 1'b1, 8'd0,   1'b1, 1'b1, 1'b0, 1'b1, 11'd0,   8'd0,   8'd0,   8'd2);
    add(1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 1'b1, 1'b0, 11'd0,   8'd0,   8'd0,   8'd3);
    // 7,9 then clear with a simultaneous y=50, then 1,2,3,4
    add(1'b0, 1'b1, 8'd7,   1'b0, 1'b0, 1'b1, 1'b0, 11'd0,   8'd0,   8'd0,   8'd3);
    add(1'b0, 1'b1, 8'd9,   1'b0, 1'b0, 1'b1, 1'b0, 11'd0,   8'd0,   8'd0,   8'd3);
    add(1'b1, 1'b1, 8'd50,  1'b0, 1'b0, 1'b1, 1'b0, 11'd0,   8'd0,   8'd0,   8'd3);
    add(1'b0, 1'b1, 8'd1,   1'b0, 1'b0, 1'b1, 1'b0, 11'd0,   8'd0,   8'd0,   8'd3);
    add(1'b0, 1'b1, 8'd2,   1'b0, 1'b0, 1'b1, 1'b0, 11'd0,   8'd0,   8'd0,   8'd3);
    add(1'b0, 1'b1, 8'd3,   1'b0, 1'b0, 1'b1, 1'b0, 11'd0,   8'd0,   8'd0,   8'd3);
    add(1'b0, 1'b1, 8'd4,   1'b0, 1'b1, 1'b0, 1'b1, 11'd10,  8'd4,   8'd1,   8'd3);
    add(1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 1'b1, 1'b0, 11'd0,   8'd0,   8'd0,   8'd4);
    // Gapped block 5,3,9,3 with junk on idle cycles and a min tie
    add(1'b0, 1'b1, 8'd5,   1'b0, 1'b0, 1'b1, 1'b0, 11'd0,   8'd0,   8'd0,   8'd4);
    add(1'b0, 1'b0, 8'd200, 1'b0, 1'b0, 1'b1, 1'b0, 11'd0,   8'd0,   8'd0,   8'd4);
    add(1'b0, 1'b1, 8'd3,   1'b0, 1'b0, 1'b1, 1'b0, 11'd0,   8'd0,   8'd0,   8'd4);
    add(1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 1'b1, 1'b0, 11'd0,   8'd0,   8'd0,   8'd4);
    add(1'b0, 1'b1, 8'd9,   1'b0, 1'b0, 1'b1, 1'b0, 11'd0,   8'd0,   8'd0,   8'd4);
    add(1'b0, 1'b1, 8'd3,   1'b0, 1'b1, 1'b0, 1'b1, 11'd20,  8'd9,   8'd3,   8'd4);
    add(1'b0, 1'b0, 8'd0,   1'b1, 1'b0, 1'b1, 1'b0, 11'd0,   8'd0,   8'd0,   8'd5);

    // Reset for two cycles, then release
    tick();
    check("reset_held", 1'b0, 1'b1, 1'b1, 11'd0, 8'd0, 8'd0, 8'd0);
    tick();
    reset = 1'b1;
    tick();
    check("after_reset", 1'b0, 1'b1, 1'b1, 11'd0, 8'd0, 8'd0, 8'd0);

    for (int i = 0; i < vt.size(); i++) begin
      drive(vt[i].clr, vt[i].vld, vt[i].y, vt[i].ordy);
      tick();
      check($sformatf("vec%0d", i), vt[i].ov, vt[i].ir, vt[i].cd,
            vt[i].sum, vt[i].mx, vt[i].mn, vt[i].cnt);
    end

    // Mid-block asynchronous reset after three gapped samples
    drive(1'b0, 1'b1, 8'd20, 1'b0); tick();
    drive(1'b0, 1'b0, 8'd0,  1'b0); tick();
    drive(1'b0, 1'b1, 8'd30, 1'b0); tick();
    drive(1'b0, 1'b0, 8'd0,  1'b0); tick();
    drive(1'b0, 1'b1, 8'd40, 1'b0); tick();
    drive(1'b0, 1'b0, 8'd0,  1'b0);
    reset = 1'b0;
    #2;
    check("async_reset_now", 1'b0, 1'b1, 1'b1, 11'd0, 8'd0, 8'd0, 8'd0);
    tick();
    tick();
    reset = 1'b1;
    drive(1'b0, 1'b1, 8'd1,   1'b0); tick();
    drive(1'b0, 1'b1, 8'd100, 1'b0); tick();
    drive(1'b0, 1'b1, 8'd50,  1'b0); tick();
    check("fresh_block_partial", 1'b0, 1'b1, 1'b0, 11'd0, 8'd0, 8'd0, 8'd0);
    drive(1'b0, 1'b1, 8'd2,   1'b0); tick();
    check("fresh_block", 1'b1, 1'b0, 1'b1, 11'd153, 8'd100, 8'd1, 8'd0);

    // Reset in HOLD discards the pending result
    reset = 1'b0;
    #2;
    check("reset_in_hold", 1'b0, 1'b1, 1'b1, 11'd0, 8'd0, 8'd0, 8'd0);
    tick();
    reset = 1'b1;
    drive(1'b0, 1'b0, 8'd0, 1'b0); tick();

    // 256 blocks: blk_cnt wraps 255 -> 0; last block is 8,7,6,5
    for (int b = 0; b < 256; b++) begin
      for (int s = 0; s < 4; s++) begin
        drive(1'b0, 1'b1, 8'(8 - s), 1'b1);
        tick();
      end
      if (b == 255) begin
        check("wrap_last_result", 1'b1, 1'b0, 1'b1, 11'd26, 8'd8, 8'd5, 8'd255);
      end
      drive(1'b0, 1'b0, 8'd0, 1'b1);
      tick();
    end
    check("blk_cnt_wrap", 1'b0, 1'b1, 1'b0, 11'd0, 8'd0, 8'd0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
